// File: rtl/m68k_bus_pkg.sv
// Shared types and limits for 68000-bus target blocks.
package m68k_bus_pkg;

    localparam int unsigned M68K_AW = 23;
    localparam int unsigned M68K_DW = 16;

    // Legal ranges for the wait-state and bus-error timeout parameters
    localparam int unsigned WAIT_STATES_MAX = 7;
    localparam int unsigned TIMEOUT_MIN     = 2;
    localparam int unsigned TIMEOUT_MAX     = 255;

    // Counter widths sized to the range limits above
    localparam int unsigned WAIT_CNT_W = 3;
    localparam int unsigned TMO_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACK   = 2'd2,
        ABORT = 2'd3
    } bus_state_e;

endpackage

// File: rtl/m68k_addr_decode.sv
// Combinational window hit: strobes active and masked address matches the base.
module m68k_addr_decode
    import m68k_bus_pkg::*;
#(
    parameter logic [M68K_AW-1:0] BASE_ADDR = '0,
    parameter logic [M68K_AW-1:0] ADDR_MASK = '0
) (
    input  logic [M68K_AW-1:0] addr,
    input  logic               as_n,
    input  logic               uds_n,
    input  logic               lds_n,
    output logic               hit_c
);

    // Address strobe, at least one data strobe, and every compared bit equal
    assign hit_c = !as_n && (!uds_n || !lds_n) &&
                   (((addr ^ BASE_ADDR) & ADDR_MASK) == '0);

endmodule

// File: rtl/m68k_bus_target.sv
// 68000-bus target: decodes a window, runs one backing-store transfer, returns DTACK.
// Optional feature macro: BERR_TIMEOUT_EN (bus error after TIMEOUT clocks without mem_ack).
module m68k_bus_target
    import m68k_bus_pkg::*;
#(
    parameter logic [M68K_AW-1:0] BASE_ADDR   = 23'h780000,
    parameter logic [M68K_AW-1:0] ADDR_MASK   = 23'h7F0000,
    parameter int unsigned        WAIT_STATES = 0,
    parameter int unsigned        TIMEOUT     = 16
) (
    input  logic               M68K_CLK,
    input  logic               M68K_RESET,
    input  logic [M68K_AW-1:0] M68K_A,
    input  logic               M68K_AS_n,
    input  logic               M68K_UDS_n,
    input  logic               M68K_LDS_n,
    input  logic               M68K_RW,
    input  logic [M68K_DW-1:0] M68K_D_IN,
    output logic [M68K_DW-1:0] M68K_D_OUT,
    output logic               M68K_D_OE,
    output logic               M68K_DTACK_n,
    output logic               M68K_BERR_n,
    output logic               mem_req,
    output logic               mem_we,
    output logic [M68K_AW-1:0] mem_addr,
    output logic [1:0]         mem_be,
    output logic [M68K_DW-1:0] mem_wdata,
    input  logic [M68K_DW-1:0] mem_rdata,
    input  logic               mem_ack
);

    // Parameter range guards, evaluated at elaboration
    if (WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait
        $error("m68k_bus_target: WAIT_STATES out of range");
    end
    if (TIMEOUT < TIMEOUT_MIN || TIMEOUT > TIMEOUT_MAX) begin : g_bad_timeout
        $error("m68k_bus_target: TIMEOUT out of range");
    end

    // BASE_ADDR/ADDR_MASK are byte addresses; the bus presents A[23:1], so align them
    localparam logic [M68K_AW-1:0] BASE_A = BASE_ADDR >> 1;
    localparam logic [M68K_AW-1:0] MASK_A = ADDR_MASK >> 1;

    bus_state_e              state_q, state_d;
    logic                    armed_q, armed_d;
    logic                    acked_q, acked_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [M68K_AW-1:0]      mem_addr_q, mem_addr_d;
    logic [1:0]              mem_be_q, mem_be_d;
    logic [M68K_DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic [M68K_DW-1:0]      d_out_q, d_out_d;
    logic                    d_oe_q, d_oe_d;
    logic                    dtack_n_q, dtack_n_d;
    logic                    hit_c;
    logic                    as_high;
`ifdef BERR_TIMEOUT_EN
    logic [TMO_CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                    berr_n_q, berr_n_d;
`endif

    m68k_addr_decode #(
        .BASE_ADDR (BASE_A),
        .ADDR_MASK (MASK_A)
    ) u_decode (
        .addr  (M68K_A),
        .as_n  (M68K_AS_n),
        .uds_n (M68K_UDS_n),
        .lds_n (M68K_LDS_n),
        .hit_c (hit_c)
    );

    assign as_high = M68K_AS_n;

    // Next-state and output computation for the bus cycle
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        acked_d     = acked_q;
        wait_cnt_d  = wait_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        d_out_d     = d_out_q;
        d_oe_d      = d_oe_q;
        dtack_n_d   = dtack_n_q;
`ifdef BERR_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        berr_n_d    = berr_n_q;
        if (as_high) begin
            berr_n_d = 1'b1;
        end
`endif
        // A rising AS is needed before the next transfer is accepted
        if (as_high) begin
            armed_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (hit_c && armed_q) begin
                    state_d     = REQ;
                    armed_d     = 1'b0;
                    acked_d     = 1'b0;
                    wait_cnt_d  = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~M68K_RW;
                    mem_addr_d  = M68K_A;
                    mem_be_d    = {~M68K_UDS_n, ~M68K_LDS_n};
                    mem_wdata_d = M68K_D_IN;
`ifdef BERR_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (!acked_q) begin
                    if (as_high) begin
                        // Cycle ended by the master; an ack on this edge is simply dropped
                        if (mem_ack) begin
                            mem_req_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            state_d   = ABORT;
                        end
                    end else if (mem_ack) begin
                        mem_req_d = 1'b0;
                        acked_d   = 1'b1;
                        if (!mem_we_q) begin
                            d_out_d = mem_rdata;
                        end
                    end
`ifdef BERR_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_CNT_W'(TIMEOUT - 1)) begin
                        berr_n_d = 1'b0;
                        state_d  = ABORT;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                    end
`endif
                end else if (as_high) begin
                    // Master gave up during the wait states; store already completed
                    state_d = IDLE;
                end else if (wait_cnt_q == WAIT_CNT_W'(WAIT_STATES)) begin
                    dtack_n_d = 1'b0;
                    d_oe_d    = ~mem_we_q;
                    state_d   = ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
                end
            end
            ACK: begin
                if (as_high) begin
                    dtack_n_d = 1'b1;
                    d_oe_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            ABORT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge M68K_CLK) begin
        if (M68K_RESET) begin
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            acked_q     <= 1'b0;
            wait_cnt_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            d_out_q     <= '0;
            d_oe_q      <= 1'b0;
            dtack_n_q   <= 1'b1;
`ifdef BERR_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            berr_n_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            acked_q     <= acked_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            d_out_q     <= d_out_d;
            d_oe_q      <= d_oe_d;
            dtack_n_q   <= dtack_n_d;
`ifdef BERR_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            berr_n_q    <= berr_n_d;
`endif
        end
    end

    assign M68K_D_OUT   = d_out_q;
    assign M68K_D_OE    = d_oe_q;
    assign M68K_DTACK_n = dtack_n_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_be       = mem_be_q;
    assign mem_wdata    = mem_wdata_q;
`ifdef BERR_TIMEOUT_EN
    assign M68K_BERR_n  = berr_n_q;
`else
    assign M68K_BERR_n  = 1'b1;
`endif

endmodule

// File: tb/tb_m68k_bus_target.sv
// Scoreboard bench for m68k_bus_target: two instances (0 and 2 wait states) share one bus.
module tb_m68k_bus_target;
    import m68k_bus_pkg::*;

    localparam int WS_B = 2;
    localparam logic [3:0] K_REQ  = 4'd1;
    localparam logic [3:0] K_RQF  = 4'd2;
    localparam logic [3:0] K_DTK  = 4'd3;
    localparam logic [3:0] K_REL  = 4'd4;
    localparam logic [3:0] K_BERR = 4'd5;
    localparam logic [3:0] K_BREL = 4'd6;

    typedef logic [63:0] ev_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [M68K_AW-1:0] a;
    logic               as_n, uds_n, lds_n, rw;
    logic [M68K_DW-1:0] d_in;
    logic [M68K_DW-1:0] rdata;
    logic               ack;

    logic [M68K_DW-1:0] d_out     [2];
    logic               d_oe      [2];
    logic               dtack_n   [2];
    logic               berr_n    [2];
    logic               mem_req   [2];
    logic               mem_we    [2];
    logic [M68K_AW-1:0] mem_addr  [2];
    logic [1:0]         mem_be    [2];
    logic [M68K_DW-1:0] mem_wdata [2];

    ev_t                exp_q[$];
    int                 n_chk  = 0;
    int                 n_fail = 0;
    int                 cyc    = 0;
    logic [M68K_DW-1:0] last_rd = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    m68k_bus_target #(.WAIT_STATES(0)) u_dut0 (
        .M68K_CLK(clk), .M68K_RESET(rst), .M68K_A(a), .M68K_AS_n(as_n),
        .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_D_IN(d_in),
        .M68K_D_OUT(d_out[0]), .M68K_D_OE(d_oe[0]), .M68K_DTACK_n(dtack_n[0]),
        .M68K_BERR_n(berr_n[0]), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_be(mem_be[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(rdata), .mem_ack(ack)
    );

    m68k_bus_target #(.WAIT_STATES(WS_B)) u_dut1 (
        .M68K_CLK(clk), .M68K_RESET(rst), .M68K_A(a), .M68K_AS_n(as_n),
        .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw), .M68K_D_IN(d_in),
        .M68K_D_OUT(d_out[1]), .M68K_D_OE(d_oe[1]), .M68K_DTACK_n(dtack_n[1]),
        .M68K_BERR_n(berr_n[1]), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_be(mem_be[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(rdata), .mem_ack(ack)
    );

    function automatic ev_t mk(input logic [3:0] k, input int d, input logic [47:0] v);
        return {k, 3'b000, 1'(d), 8'h00, v};
    endfunction

    function automatic string kname(input logic [3:0] k);
        case (k)
            K_REQ:   return "mem_req_rise";
            K_RQF:   return "mem_req_fall";
            K_DTK:   return "dtack_assert";
            K_REL:   return "dtack_release";
            K_BERR:  return "berr_assert";
            K_BREL:  return "berr_release";
            default: return "event";
        endcase
    endfunction

    // Expected-event helpers (delays: RQF/DTK from the ack edge, REL/BREL from the AS-high edge, BERR from req)
    task automatic exp_req(input logic we, input logic [1:0] be, input logic [22:0] ad, input logic [15:0] wd);
        exp_q.push_back(mk(K_REQ, 0, {6'b0, we, be, ad, wd}));
    endtask
    task automatic exp_rqf();
        exp_q.push_back(mk(K_RQF, 0, 48'd0));
    endtask
    task automatic exp_dtk(input int d, input logic [15:0] dv, input logic oe, input int dly);
        exp_q.push_back(mk(K_DTK, d, {23'b0, dv, oe, 8'(dly)}));
    endtask
    task automatic exp_rel(input int d);
        exp_q.push_back(mk(K_REL, d, {39'b0, 1'b0, 8'd0}));
    endtask
    task automatic exp_berr(input int d, input int dly);
        exp_q.push_back(mk(K_BERR, d, {40'b0, 8'(dly)}));
    endtask
    task automatic exp_brel(input int d);
        exp_q.push_back(mk(K_BREL, d, 48'd0));
    endtask

    task automatic observe(input ev_t got);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected %s got=%h", kname(got[63:60]), got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s got=%h exp=%h", kname(e[63:60]), got, e);
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: turns output edges into events and checks them against the queue
    logic req_prev = 1'b0;
    logic dtk_prev [2] = '{1'b1, 1'b1};
    logic berr_prev[2] = '{1'b1, 1'b1};
    logic as_prev = 1'b1;
    int   mark_cyc = 0;
    int   as_cyc   = 0;
    int   req_cyc  = 0;

    always @(negedge clk) begin
        if (ack || rst) mark_cyc = cyc + 1;
        if (as_n && !as_prev) as_cyc = cyc + 1;
        as_prev = as_n;
        if (mem_req[0] && !req_prev) begin
            req_cyc = cyc;
            observe(mk(K_REQ, 0, {6'b0, mem_we[0], mem_be[0], mem_addr[0], mem_wdata[0]}));
        end
        if (!mem_req[0] && req_prev)
            observe(mk(K_RQF, 0, 48'(cyc - mark_cyc)));
        req_prev = mem_req[0];
        for (int d = 0; d < 2; d++) begin
            if (!dtack_n[d] && dtk_prev[d])
                observe(mk(K_DTK, d, {23'b0, d_out[d], d_oe[d], 8'(cyc - mark_cyc)}));
            if (dtack_n[d] && !dtk_prev[d])
                observe(mk(K_REL, d, {39'b0, d_oe[d], 8'(cyc - as_cyc)}));
            if (!berr_n[d] && berr_prev[d])
                observe(mk(K_BERR, d, {40'b0, 8'(cyc - req_cyc)}));
            if (berr_n[d] && !berr_prev[d])
                observe(mk(K_BREL, d, {40'b0, 8'(cyc - as_cyc)}));
            dtk_prev[d]  = dtack_n[d];
            berr_prev[d] = berr_n[d];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start(input logic [22:0] ad, input logic r, input logic u, input logic l, input logic [15:0] dv);
        a = ad; rw = r; uds_n = u; lds_n = l; d_in = dv; as_n = 1'b0;
    endtask

    task automatic bus_end();
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    endtask

    task automatic ack_pulse(input logic [15:0] rd);
        rdata = rd; ack = 1'b1;
        tick(1);
        ack = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_req_we_be"}, {61'b0, mem_req[d], mem_we[d], mem_be[d]}, 64'd0);
            check({tag, "_addr"},      64'(mem_addr[d]), 64'd0);
            check({tag, "_wdata_dout"}, {32'b0, mem_wdata[d], d_out[d]}, 64'd0);
            check({tag, "_oe_dtk_berr"}, {61'b0, d_oe[d], dtack_n[d], berr_n[d]}, 64'd3);
        end
    endtask

    // Complete transfer: hit, ack two clocks after req, then AS released
    task automatic xfer(input logic r, input logic [22:0] ad, input logic u, input logic l,
                        input logic [15:0] dv, input logic [15:0] rd);
        logic [15:0] dexp;
        dexp = r ? rd : last_rd;
        exp_req(~r, {~u, ~l}, ad, dv);
        exp_rqf();
        exp_dtk(0, dexp, r, 1);
        exp_dtk(1, dexp, r, 1 + WS_B);
        exp_rel(0);
        exp_rel(1);
        bus_start(ad, r, u, l, dv);
        tick(2);
        ack_pulse(rd);
        tick(4);
        bus_end();
        tick(2);
        last_rd = dexp;
    endtask

    initial begin
        rst = 1'b1; a = '0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
        d_in = '0; rdata = '0; ack = 1'b0;
        tick(3);
        check_reset("reset");
        rst = 1'b0;
        tick(2);

        // Word read at byte 0x780010
        xfer(1'b1, 23'h3C0008, 1'b0, 1'b0, 16'h0000, 16'hBEEF);

        // Odd-byte write on LDS only; read data bus must stay undriven
        xfer(1'b0, 23'h3C0020, 1'b1, 1'b0, 16'h0012, 16'h5555);

        // Address outside the window
        bus_start(23'h080000, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(4);
        check("miss_req", {63'b0, mem_req[0]}, 64'd0);
        check("miss_dtk_berr", {60'b0, dtack_n[0], berr_n[0], dtack_n[1], berr_n[1]}, 64'hF);
        bus_end();
        tick(2);

        // AS negated one clock after req; late ack is discarded
        exp_req(1'b0, 2'b11, 23'h3C0030, 16'h0000);
        exp_rqf();
        bus_start(23'h3C0030, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1);
        bus_end();
        tick(3);
        check("abort_req_held", {63'b0, mem_req[0]}, 64'd1);
        ack_pulse(16'hDEAD);
        check("abort_dout_kept", 64'(d_out[0]), 64'(last_rd));
        xfer(1'b1, 23'h3C0040, 1'b0, 1'b0, 16'h0000, 16'h1234);

`ifdef BERR_TIMEOUT_EN
        // No ack: bus error after the timeout, cleared when AS rises
        exp_req(1'b0, 2'b11, 23'h3C0050, 16'h0000);
        exp_berr(0, 16);
        exp_berr(1, 16);
        exp_brel(0);
        exp_brel(1);
        exp_rqf();
        bus_start(23'h3C0050, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(20);
        bus_end();
        tick(3);
        check("berr_req_held", {63'b0, mem_req[0]}, 64'd1);
        ack_pulse(16'h5A5A);
        tick(2);
`else
        // No timeout: REQ waits for a very late ack without bus error
        exp_req(1'b0, 2'b11, 23'h3C0050, 16'h0000);
        exp_rqf();
        exp_dtk(0, 16'hCAFE, 1'b1, 1);
        exp_dtk(1, 16'hCAFE, 1'b1, 1 + WS_B);
        exp_rel(0);
        exp_rel(1);
        bus_start(23'h3C0050, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(20);
        check("late_berr", {62'b0, berr_n[0], berr_n[1]}, 64'd3);
        check("late_req_held", {63'b0, mem_req[0]}, 64'd1);
        ack_pulse(16'hCAFE);
        tick(4);
        bus_end();
        tick(2);
        last_rd = 16'hCAFE;
`endif

        // Reset pulsed while a request is outstanding
        exp_req(1'b0, 2'b11, 23'h3C0060, 16'h0000);
        exp_rqf();
        bus_start(23'h3C0060, 1'b1, 1'b0, 1'b0, 16'h0000);
        tick(2);
        rst = 1'b1;
        tick(1);
        check_reset("midreset");
        rst = 1'b0;
        bus_end();
        tick(1);
        last_rd = '0;
        xfer(1'b1, 23'h3C0070, 1'b0, 1'b0, 16'h0000, 16'h0F0F);

        tick(4);
        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing %s exp=%h", kname(e[63:60]), e);
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
